// File: rtl/vga_pixel_fifo.sv
// Pixel FIFO feeding the VGA output path: buffers producer pixels, pops one per active cycle.
// Optional statistics outputs (under_cnt, min_level) are built when VGA_FIFO_STATS_EN is defined.
module vga_pixel_fifo #(
  parameter int          DEPTH         = 1024,
  parameter int          H_ACTIVE      = 640,
  parameter int          V_ACTIVE      = 480,
  parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF
) (
  input  logic                    clk_pix,
  input  logic                    rst,
  input  logic [23:0]             s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [10:0]             H_Cont,
  input  logic [10:0]             V_Cont,
  output logic [7:0]              pix_r,
  output logic [7:0]              pix_g,
  output logic [7:0]              pix_b,
  output logic                    pix_active,
  output logic                    frame_req,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    underflow
`ifdef VGA_FIFO_STATS_EN
  ,
  output logic [15:0]             under_cnt,
  output logic [$clog2(DEPTH):0]  min_level
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FILL   = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;
  localparam logic [1:0] RESYNC = 2'd3;

  localparam logic [10:0]   H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0]   V_ACT    = 11'(V_ACTIVE);
  localparam logic [LW-1:0] DEPTH_LV = LW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [1:0]    state_reg, state_next;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0] level_reg, level_next;
  logic          frame_req_reg;
  logic          underflow_reg;
  logic          pix_active_reg;

  logic active, flush_pt, empty, full;
  logic push, pop, under_ev, show_under;
  logic [7:0] lane_q [3];

  always_comb begin
    active     = (H_Cont < H_ACT) && (V_Cont < V_ACT);
    flush_pt   = (V_Cont == V_ACT) && (H_Cont == 11'd0);
    empty      = (level_reg == '0);
    full       = (level_reg == DEPTH_LV);
    // Depends only on registered state/level and the counters, never on this cycle's pop.
    s_ready    = (state_reg != IDLE) && !flush_pt && ((state_reg == RESYNC) || !full);
    push       = s_valid && s_ready && ((state_reg == FILL) || (state_reg == STREAM));
    pop        = 1'b0;
    under_ev   = 1'b0;
    state_next = state_reg;

    if (flush_pt) begin
      state_next = FILL;
    end else begin
      case (state_reg)
        FILL, STREAM: begin
          if (active) begin
            if (empty) begin
              under_ev   = 1'b1;
              state_next = RESYNC;
            end else begin
              pop        = 1'b1;
              state_next = STREAM;
            end
          end
        end
        default: ;
      endcase
    end

    show_under = active && (under_ev || (state_reg == RESYNC));

    if (flush_pt)
      level_next = '0;
    else
      level_next = level_reg + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      frame_req_reg  <= 1'b0;
      underflow_reg  <= 1'b0;
      pix_active_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      level_reg      <= level_next;
      frame_req_reg  <= flush_pt;
      underflow_reg  <= underflow_reg | under_ev;
      pix_active_reg <= active && (state_reg != IDLE);
      if (flush_pt) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push)
          wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
        if (pop)
          rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
    end
  end

  // One byte-wide RAM per colour lane; lane 0 = B, 1 = G, 2 = R.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] lane_reg;

      always_ff @(posedge clk_pix) begin
        if (push)
          mem[wr_ptr_reg] <= s_data[gi*8 +: 8];
      end

      always_ff @(posedge clk_pix) begin
        if (rst)
          lane_reg <= 8'h00;
        else if (pop)
          lane_reg <= mem[rd_ptr_reg];
        else if (show_under)
          lane_reg <= UNDERFLOW_RGB[gi*8 +: 8];
        else
          lane_reg <= 8'h00;
      end

      assign lane_q[gi] = lane_reg;
    end
  endgenerate

  assign pix_b      = lane_q[0];
  assign pix_g      = lane_q[1];
  assign pix_r      = lane_q[2];
  assign pix_active = pix_active_reg;
  assign frame_req  = frame_req_reg;
  assign level      = level_reg;
  assign underflow  = underflow_reg;

`ifdef VGA_FIFO_STATS_EN
  logic [15:0]   under_cnt_reg;
  logic [LW-1:0] min_level_reg;

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      under_cnt_reg <= 16'h0000;
      min_level_reg <= '0;
    end else begin
      if (under_ev && (under_cnt_reg != 16'hFFFF))
        under_cnt_reg <= under_cnt_reg + 16'h0001;
      // Watermark restarts with each new frame request.
      if (frame_req_reg)
        min_level_reg <= DEPTH_LV;
      else if ((state_reg == STREAM) && (level_reg < min_level_reg))
        min_level_reg <= level_reg;
    end
  end

  assign under_cnt = under_cnt_reg;
  assign min_level = min_level_reg;
`endif

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// Bench for vga_pixel_fifo: directed frames plus random frames against a queue-based frame model.
module tb_vga_pixel_fifo;
  localparam int          DEPTH    = 8;
  localparam int          H_ACTIVE = 4;
  localparam int          V_ACTIVE = 2;
  localparam int          H_TOTAL  = 6;
  localparam int          V_TOTAL  = 4;
  localparam logic [23:0] UND_RGB  = 24'hFF00FF;

  logic        clk_pix = 1'b0;
  logic        rst     = 1'b1;
  logic [23:0] s_data  = 24'h0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [10:0] H_Cont  = 11'd0;
  logic [10:0] V_Cont  = 11'd0;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic        pix_active, frame_req, underflow;
  logic [3:0]  level;
`ifdef VGA_FIFO_STATS_EN
  logic [15:0] under_cnt;
  logic [3:0]  min_level;
`endif

  vga_pixel_fifo #(
    .DEPTH(DEPTH), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .UNDERFLOW_RGB(UND_RGB)
  ) dut (
    .clk_pix(clk_pix), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .H_Cont(H_Cont), .V_Cont(V_Cont), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_active(pix_active), .frame_req(frame_req), .level(level), .underflow(underflow)
`ifdef VGA_FIFO_STATS_EN
    , .under_cnt(under_cnt), .min_level(min_level)
`endif
  );

  always #5 clk_pix = ~clk_pix;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // Model: pixels waiting, whether a flush has been seen since reset, whether this frame broke.
  logic [23:0] q [$];
  bit          armed   = 1'b0;
  bit          broken  = 1'b0;
  bit          m_under = 1'b0;
  int          m_ucnt  = 0;
  int          h = 0;
  int          v = 0;
  logic [23:0] next_px = 24'h1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h at h=%0d v=%0d", tag, obs, exp, h, v);
    end
  endtask

  task automatic cyc(input bit v_in, input logic [23:0] d_in, input bit r_in, output bit acc);
    bit act, fl, rdy;
    logic [23:0] exp_px;
    bit exp_pact;
    H_Cont  = 11'(h);
    V_Cont  = 11'(v);
    s_valid = v_in;
    s_data  = d_in;
    rst     = r_in;
    act = (h < H_ACTIVE) && (v < V_ACTIVE);
    fl  = (v == V_ACTIVE) && (h == 0);
    rdy = armed && !fl && (broken || (q.size() < DEPTH));
    #1;
    check("s_ready", {31'd0, s_ready}, {31'd0, rdy});
    acc      = v_in && rdy && !broken;
    exp_px   = 24'h0;
    exp_pact = act && armed;
    if (r_in) begin
      q.delete();
      armed = 0; broken = 0; m_under = 0; m_ucnt = 0;
      exp_pact = 0; acc = 0;
    end else if (fl) begin
      q.delete();
      armed = 1; broken = 0;
    end else if (armed && act) begin
      if (broken) begin
        exp_px = UND_RGB;
      end else if (q.size() == 0) begin
        exp_px = UND_RGB;
        broken = 1; m_under = 1; m_ucnt++;
      end else begin
        exp_px = q.pop_front();
      end
    end
    if (acc) q.push_back(d_in);
    @(posedge clk_pix);
    #1;
    check("pix_rgb", {8'd0, pix_r, pix_g, pix_b}, {8'd0, exp_px});
    check("pix_active", {31'd0, pix_active}, {31'd0, exp_pact});
    check("frame_req", {31'd0, frame_req}, {31'd0, (fl && !r_in)});
    check("level", {28'd0, level}, 32'(q.size()));
    check("underflow", {31'd0, underflow}, {31'd0, m_under});
`ifdef VGA_FIFO_STATS_EN
    check("under_cnt", {16'd0, under_cnt}, 32'(m_ucnt));
`endif
    h++;
    if (h == H_TOTAL) begin
      h = 0;
      v = (v + 1) % V_TOTAL;
    end
  endtask

  // mode 0: offer while budget lasts; 1: also drive valid on flush cycles; 2: random gaps and data
  task automatic run(input int ncyc, input int offer, input int mode);
    bit val, acc;
    for (int i = 0; i < ncyc; i++) begin
      val = (offer > 0);
      if (mode == 2 && $urandom_range(0, 3) == 0) val = 1'b0;
      if (mode == 1 && h == 0 && v == V_ACTIVE) val = 1'b1;
      cyc(val, next_px, 1'b0, acc);
      if (acc) begin
        offer--;
        next_px = (mode == 2) ? 24'($urandom) : next_px + 24'h1;
      end
    end
  endtask

  initial begin
    bit dummy;
    @(posedge clk_pix);
    #1;
    cyc(1'b0, 24'h0, 1'b1, dummy);       // reset values
    run(11, 0, 0);                        // IDLE up to the first flush point

    next_px = 24'h1; run(24, 8, 0);       // full frame 1..8
    next_px = 24'h1; run(24, 5, 0);       // short frame -> underflow on 6th pixel
    next_px = 24'h1; run(24, 8, 0);       // recovery
    next_px = 24'h1; run(24, 100, 0);     // continuous valid, push+pop overlap
    next_px = 24'h1; run(24, 11, 0);      // leaves 3 surplus at flush
    next_px = 24'h100; run(24, 6, 1);     // valid held during flush point

    for (int f = 0; f < 6; f++) begin
      next_px = 24'($urandom);
      run(24, int'($urandom_range(0, 14)), 2);
    end

    next_px = 24'h1; run(20, 8, 0);       // up to mid-line 1
    cyc(1'b1, 24'hABCDEF, 1'b1, dummy);   // reset mid-line
    run(3, 4, 0);
    next_px = 24'h1; run(24, 8, 0);
    run(1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
